// File: rtl/leaf_stream_pkg.sv
// Shared constants and width helpers for the leaf stream FIFO bank.
// Optional stall statistics are enabled by defining LEAF_FIFO_STALL_STATS_EN.
package leaf_stream_pkg;

  localparam int MAX_CH         = 16;
  localparam int STALL_CNT_BITS = 16;

  typedef int occ_width_t;
  typedef logic [STALL_CNT_BITS-1:0] stall_cnt_t;

  // Occupancy needs one extra bit so that a completely full FIFO is representable.
  function automatic occ_width_t occ_width(input occ_width_t depth_bits);
    return depth_bits + 1;
  endfunction

endpackage

// File: rtl/leaf_stream_fifo.sv
// Single elastic FIFO channel with occupancy, freespace credit pulse and
// optional input stall counter (LEAF_FIFO_STALL_STATS_EN).
module leaf_stream_fifo
  import leaf_stream_pkg::*;
#(
  parameter int PAYLOAD_BITS          = 32,
  parameter int DEPTH_BITS            = 4,
  parameter int FREESPACE_UPDATE_SIZE = 8
) (
  input  logic                               clk_user,
  input  logic                               reset,
  input  logic [PAYLOAD_BITS-1:0]            din,
  input  logic                               din_vld,
  output logic                               din_ack,
  output logic [PAYLOAD_BITS-1:0]            dout,
  output logic                               dout_vld,
  input  logic                               dout_ack,
  output logic [occ_width(DEPTH_BITS)-1:0]   occupancy,
  output logic                               credit_pulse,
  output stall_cnt_t                         stall_cnt
);

  localparam int OCC_W = occ_width(DEPTH_BITS);
  localparam int CRD_W = $clog2(FREESPACE_UPDATE_SIZE) + 1;
  localparam logic [OCC_W-1:0] FULL     = OCC_W'(2 ** DEPTH_BITS);
  localparam logic [CRD_W-1:0] CRD_LAST = CRD_W'(FREESPACE_UPDATE_SIZE - 1);

  logic [PAYLOAD_BITS-1:0] mem [2 ** DEPTH_BITS];
  logic [DEPTH_BITS-1:0]   wr_ptr;
  logic [DEPTH_BITS-1:0]   rd_ptr;
  logic [CRD_W-1:0]        crd_cnt;
  logic                    ready;
  logic                    push;
  logic                    pop;

  // ready holds din_ack low until the first edge after reset is released.
  assign din_ack  = ready && (occupancy != FULL);
  assign dout_vld = (occupancy != '0);
  assign dout     = dout_vld ? mem[rd_ptr] : '0;
  assign push     = din_vld && din_ack;
  assign pop      = dout_vld && dout_ack;

  always_ff @(posedge clk_user) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_user or negedge reset) begin
    if (!reset) begin
      ready     <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      ready <= 1'b1;
      if (push) wr_ptr <= wr_ptr + DEPTH_BITS'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_BITS'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clk_user or negedge reset) begin
    if (!reset) begin
      crd_cnt      <= '0;
      credit_pulse <= 1'b0;
    end else begin
      credit_pulse <= 1'b0;
      if (pop) begin
        if (crd_cnt == CRD_LAST) begin
          crd_cnt      <= '0;
          credit_pulse <= 1'b1;
        end else begin
          crd_cnt <= crd_cnt + CRD_W'(1);
        end
      end
    end
  end

`ifdef LEAF_FIFO_STALL_STATS_EN
  always_ff @(posedge clk_user or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (din_vld && !din_ack && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_BITS'(1);
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: rtl/leaf_stream_fifo_bank.sv
// Bank of NUM_CH independent leaf_stream_fifo channels; only slices the buses.
// Stall statistics are compiled in when LEAF_FIFO_STALL_STATS_EN is defined.
module leaf_stream_fifo_bank
  import leaf_stream_pkg::*;
#(
  parameter int NUM_CH                = 2,
  parameter int PAYLOAD_BITS          = 32,
  parameter int DEPTH_BITS            = 4,
  parameter int FREESPACE_UPDATE_SIZE = 8
) (
  input  logic                                     clk_user,
  input  logic                                     reset,
  input  logic [NUM_CH*PAYLOAD_BITS-1:0]           din,
  input  logic [NUM_CH-1:0]                        din_vld,
  output logic [NUM_CH-1:0]                        din_ack,
  output logic [NUM_CH*PAYLOAD_BITS-1:0]           dout,
  output logic [NUM_CH-1:0]                        dout_vld,
  input  logic [NUM_CH-1:0]                        dout_ack,
  output logic [NUM_CH*occ_width(DEPTH_BITS)-1:0]  occupancy,
  output logic [NUM_CH-1:0]                        credit_pulse,
  output logic [NUM_CH*STALL_CNT_BITS-1:0]         stall_cnt
);

  localparam int OCC_W = occ_width(DEPTH_BITS);

  for (genvar c = 0; (c < NUM_CH) && (c < MAX_CH); c++) begin : g_ch
    leaf_stream_fifo #(
      .PAYLOAD_BITS         (PAYLOAD_BITS),
      .DEPTH_BITS           (DEPTH_BITS),
      .FREESPACE_UPDATE_SIZE(FREESPACE_UPDATE_SIZE)
    ) u_fifo (
      .clk_user    (clk_user),
      .reset       (reset),
      .din         (din[c*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .din_vld     (din_vld[c]),
      .din_ack     (din_ack[c]),
      .dout        (dout[c*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .dout_vld    (dout_vld[c]),
      .dout_ack    (dout_ack[c]),
      .occupancy   (occupancy[c*OCC_W +: OCC_W]),
      .credit_pulse(credit_pulse[c]),
      .stall_cnt   (stall_cnt[c*STALL_CNT_BITS +: STALL_CNT_BITS])
    );
  end

endmodule

// File: tb/tb_leaf_stream_fifo_bank.sv
// Self-checking bench for leaf_stream_fifo_bank: directed table, corner sequences,
// random traffic against a queue-based model (honours LEAF_FIFO_STALL_STATS_EN).
module tb_leaf_stream_fifo_bank;

  localparam int NUM_CH = 2;
  localparam int P      = 32;
  localparam int D      = 4;
  localparam int F      = 8;
  localparam int DEPTH  = 2 ** D;
  localparam int OW     = D + 1;

  logic                   clk_user = 1'b0;
  logic                   reset;
  logic [NUM_CH*P-1:0]    din;
  logic [NUM_CH-1:0]      din_vld;
  logic [NUM_CH-1:0]      din_ack;
  logic [NUM_CH*P-1:0]    dout;
  logic [NUM_CH-1:0]      dout_vld;
  logic [NUM_CH-1:0]      dout_ack;
  logic [NUM_CH*OW-1:0]   occupancy;
  logic [NUM_CH-1:0]      credit_pulse;
  logic [NUM_CH*16-1:0]   stall_cnt;

  leaf_stream_fifo_bank #(
    .NUM_CH(NUM_CH), .PAYLOAD_BITS(P), .DEPTH_BITS(D), .FREESPACE_UPDATE_SIZE(F)
  ) dut (
    .clk_user(clk_user), .reset(reset), .din(din), .din_vld(din_vld),
    .din_ack(din_ack), .dout(dout), .dout_vld(dout_vld), .dout_ack(dout_ack),
    .occupancy(occupancy), .credit_pulse(credit_pulse), .stall_cnt(stall_cnt)
  );

  always #5 clk_user = ~clk_user;

  // Reference model: one queue per channel plus pop/stall totals.
  logic [P-1:0] mq [NUM_CH][$];
  int           m_pops  [NUM_CH];
  bit           m_pulse [NUM_CH];
  int           m_stall [NUM_CH];
  bit           m_ready;
  int           n_checks = 0;
  int           n_fail   = 0;

  typedef struct {
    logic [1:0]  vld;
    logic [63:0] data;
    logic [1:0]  ack;
    logic [4:0]  occ0;
    logic [4:0]  occ1;
    logic [31:0] dout0;
    logic [31:0] dout1;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int ch, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s ch%0d: got 0x%0h, expected 0x%0h", name, ch, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      mq[c].delete();
      m_pops[c]  = 0;
      m_pulse[c] = 1'b0;
      m_stall[c] = 0;
    end
    m_ready = 1'b0;
  endfunction

  task automatic checkOutput(input string tag);
    for (int c = 0; c < NUM_CH; c++) begin
      logic [P-1:0] head;
      int           exp_stall;
      head = (mq[c].size() != 0) ? mq[c][0] : '0;
`ifdef LEAF_FIFO_STALL_STATS_EN
      exp_stall = m_stall[c];
`else
      exp_stall = 0;
`endif
      check({tag, ".din_ack"},   c, 64'(din_ack[c]),  64'(m_ready && (mq[c].size() < DEPTH)));
      check({tag, ".dout_vld"},  c, 64'(dout_vld[c]), 64'(mq[c].size() != 0));
      check({tag, ".dout"},      c, 64'(dout[c*P +: P]), 64'(head));
      check({tag, ".occupancy"}, c, 64'(occupancy[c*OW +: OW]), 64'(mq[c].size()));
      check({tag, ".credit"},    c, 64'(credit_pulse[c]), 64'(m_pulse[c]));
      check({tag, ".stall_cnt"}, c, 64'(stall_cnt[c*16 +: 16]), 64'(exp_stall));
    end
  endtask

  // Drives one cycle of inputs from just after a falling edge, advances the model
  // across the rising edge and returns at the next falling edge.
  task automatic applyStimulus(input logic [NUM_CH-1:0] vld, input logic [NUM_CH*P-1:0] data,
                               input logic [NUM_CH-1:0] ack);
    bit do_push [NUM_CH];
    bit do_pop  [NUM_CH];
    bit stalled [NUM_CH];
    din_vld  = vld;
    din      = data;
    dout_ack = ack;
    for (int c = 0; c < NUM_CH; c++) begin
      do_push[c] = vld[c] && m_ready && (mq[c].size() < DEPTH);
      stalled[c] = vld[c] && !(m_ready && (mq[c].size() < DEPTH));
      do_pop[c]  = ack[c] && (mq[c].size() != 0);
    end
    @(posedge clk_user);
    for (int c = 0; c < NUM_CH; c++) begin
      m_pulse[c] = 1'b0;
      if (do_pop[c]) begin
        void'(mq[c].pop_front());
        m_pops[c]++;
        m_pulse[c] = (m_pops[c] % F) == 0;
      end
      if (do_push[c]) mq[c].push_back(data[c*P +: P]);
      if (stalled[c] && m_stall[c] < 65535) m_stall[c]++;
    end
    m_ready = 1'b1;
    @(negedge clk_user);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #1;
    checkOutput("reset");
    @(negedge clk_user);
    reset = 1'b1;
    applyStimulus('0, '0, '0);
    checkOutput("post_reset");
  endtask

  initial begin
    int pulses;
    reset    = 1'b0;
    din      = '0;
    din_vld  = '0;
    dout_ack = '0;
    model_reset();

    vecs[0] = '{2'b01, {32'h0, 32'hDEADBEEF},        2'b00, 5'd1, 5'd0, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{2'b11, {32'h22222222, 32'h11111111}, 2'b00, 5'd2, 5'd1, 32'hDEADBEEF, 32'h22222222};
    vecs[2] = '{2'b00, 64'h0,                        2'b01, 5'd1, 5'd1, 32'h11111111, 32'h22222222};
    vecs[3] = '{2'b01, {32'h0, 32'h33333333},        2'b01, 5'd1, 5'd1, 32'h33333333, 32'h22222222};
    vecs[4] = '{2'b00, 64'h0,                        2'b11, 5'd0, 5'd0, 32'h0,        32'h0};
    vecs[5] = '{2'b00, 64'h0,                        2'b11, 5'd0, 5'd0, 32'h0,        32'h0};

    repeat (2) @(negedge clk_user);
    checkOutput("reset_hold");
    reset = 1'b1;
    applyStimulus('0, '0, '0);
    checkOutput("release");

    // Directed table: single push, dual push, pop, push+pop, drain, underflow.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].vld, vecs[i].data, vecs[i].ack);
      checkOutput("vec");
      check("vec.occ0",  i, 64'(occupancy[0 +: OW]),  64'(vecs[i].occ0));
      check("vec.occ1",  i, 64'(occupancy[OW +: OW]), 64'(vecs[i].occ1));
      check("vec.dout0", i, 64'(dout[31:0]),          64'(vecs[i].dout0));
      check("vec.dout1", i, 64'(dout[63:32]),         64'(vecs[i].dout1));
    end

    // Fill channel 1, attempt a 17th push, then drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(2'b10, {32'(i), 32'h0}, 2'b00);
      checkOutput("fill");
    end
    check("full.din_ack", 1, 64'(din_ack[1]), 64'd0);
    check("full.occ", 1, 64'(occupancy[OW +: OW]), 64'(DEPTH));
    applyStimulus(2'b10, {32'd99, 32'h0}, 2'b00);
    checkOutput("overflow");
    check("overflow.occ", 1, 64'(occupancy[OW +: OW]), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      check("drain.order", 1, 64'(dout[63:32]), 64'(i));
      applyStimulus(2'b00, '0, 2'b10);
      checkOutput("drain");
    end

    // Steady push+pop at occupancy 5 across pointer wrap.
    for (int i = 0; i < 5; i++) applyStimulus(2'b01, {32'h0, 32'(100 + i)}, 2'b00);
    for (int i = 0; i < 20; i++) begin
      check("stream.head", 0, 64'(dout[31:0]), 64'(100 + i));
      applyStimulus(2'b01, {32'h0, 32'(105 + i)}, 2'b01);
      checkOutput("stream");
      check("stream.occ", 0, 64'(occupancy[0 +: OW]), 64'd5);
    end

    // Credit pulses: 24 pops on channel 0 from a clean credit counter.
    do_reset();
    for (int i = 0; i < 8; i++) applyStimulus(2'b01, {32'h0, 32'(200 + i)}, 2'b00);
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      applyStimulus(2'b01, {32'h0, 32'(208 + i)}, 2'b01);
      checkOutput("credit");
      check("credit.timing", 0, 64'(credit_pulse[0]), 64'(((i + 1) % 8) == 0));
      pulses += int'(credit_pulse[0]);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus('0, '0, '0);
      pulses += int'(credit_pulse[0]);
    end
    check("credit.count", 0, 64'(pulses), 64'd3);

    // Asynchronous reset with 9 entries in flight.
    applyStimulus(2'b01, {32'h0, 32'h12345678}, 2'b00);
    check("pre_reset.occ", 0, 64'(occupancy[0 +: OW]), 64'd9);
    #2 reset = 1'b0;
    model_reset();
    #1;
    checkOutput("async_reset");
    check("async_reset.vld", 0, 64'(dout_vld[0]), 64'd0);
    @(negedge clk_user);
    reset = 1'b1;
    applyStimulus('0, '0, '0);
    applyStimulus(2'b01, {32'h0, 32'hABCD0001}, 2'b00);
    checkOutput("after_reset");
    check("after_reset.head", 0, 64'(dout[31:0]), 64'hABCD0001);

    // Stall statistics: hold channel 0 full with din_vld high for 10 cycles.
    do_reset();
    for (int i = 0; i < DEPTH; i++) applyStimulus(2'b01, {32'h0, 32'(i)}, 2'b00);
    for (int i = 0; i < 10; i++) applyStimulus(2'b01, {32'h0, 32'hFFFF0000}, 2'b00);
    checkOutput("stall");
`ifdef LEAF_FIFO_STALL_STATS_EN
    check("stall.count", 0, 64'(stall_cnt[15:0]), 64'd10);
`else
    check("stall.count", 0, 64'(stall_cnt[15:0]), 64'd0);
`endif

    // Random traffic with varying accept density.
    for (int i = 0; i < 400; i++) begin
      logic [NUM_CH-1:0] vld;
      logic [NUM_CH-1:0] ack;
      vld = NUM_CH'($urandom);
      ack = (i % 100 < 50) ? NUM_CH'($urandom) & NUM_CH'($urandom) : NUM_CH'($urandom) | NUM_CH'($urandom);
      applyStimulus(vld, {$urandom, $urandom}, ack);
      checkOutput("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
